// File: rtl/config_pkg.sv
// Shared opcodes, FSM state type and packet constants for the stream ALU.
package config_pkg;
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'hAC;
  localparam logic [7:0] OP_DIV  = 8'hD1;
  localparam int         HDR_LEN = 4;

  typedef enum logic [3:0] {
    S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_OPND, S_DIVW, S_EMIT, S_ECHO, S_DRAIN
  } alu_state_e;

  function automatic logic is_arith(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
  endfunction
endpackage

// File: rtl/stream_alu_if.sv
// Byte-stream in/out handshakes plus busy flag between UART RX, ALU and UART TX.
interface stream_alu_if;
  logic [7:0] in_data_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       busy_o;

  modport slave  (input  in_data_i, in_valid_i, out_ready_i,
                  output in_ready_o, out_data_o, out_valid_o, busy_o);
  modport master (output in_data_i, in_valid_i, out_ready_i,
                  input  in_ready_o, out_data_o, out_valid_o, busy_o);
endinterface

// File: rtl/alu_div_iter.sv
// Restoring divider, one quotient bit per cycle; done/quotient are valid in the
// DATA_W-th cycle after start. A zero divisor yields an all-ones quotient.
module alu_div_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] rem_q, rem_d, q_q, q_d, div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W:0]   rem_sh, diff;
  logic              ge;
  logic [DATA_W-1:0] rem_nxt, q_nxt;

  always_comb begin
    rem_sh  = {rem_q, q_q[DATA_W-1]};
    diff    = rem_sh - {1'b0, div_q};
    ge      = !diff[DATA_W];
    rem_nxt = ge ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    q_nxt   = {q_q[DATA_W-2:0], ge};
    rem_d = rem_q;
    q_d   = q_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (start) begin
      rem_d = '0;
      q_d   = dividend;
      div_d = divisor;
      cnt_d = CNT_W'(DATA_W);
    end else if (cnt_q != '0) begin
      rem_d = rem_nxt;
      q_d   = q_nxt;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Last step is exposed combinationally so the caller spends exactly DATA_W cycles.
  assign done     = (cnt_q == CNT_W'(1));
  assign quotient = (div_q == '0) ? '1 : q_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q <= '0; q_q <= '0; div_q <= '0; cnt_q <= '0;
    end else begin
      rem_q <= rem_d; q_q <= q_d; div_q <= div_d; cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/stream_alu.sv
// Packet parser + accumulator: ADD/MUL/DIV reduce little-endian operands to one
// result sent LSB first, ECHO forwards payload, unknown opcodes drain it.
module stream_alu
  import config_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  stream_alu_if.slave  bus
);
  localparam int BYTES_W = DATA_W / 8;
  localparam int BC_W    = (BYTES_W > 1) ? $clog2(BYTES_W) : 1;

  alu_state_e        state_q, state_d;
  logic [7:0]        op_q, op_d, out_data_q, out_data_d;
  logic [15:0]       len_q, len_d, len_hdr;
  logic [DATA_W-1:0] opnd_q, opnd_d, acc_q, acc_d, opnd_nxt, res, acc_sh;
  logic [BC_W-1:0]   bcnt_q, bcnt_d, ecnt_q, ecnt_d;
  logic              first_q, first_d, last_q, last_d, out_valid_q, out_valid_d;
  logic              init_q, en, in_rdy, take, last_byte, opnd_done, emit;
  logic              div_start, div_done;
  logic [DATA_W-1:0] div_quot;

  alu_div_iter #(.DATA_W(DATA_W)) u_div (
    .clk(clk), .rst(rst), .start(div_start), .dividend(acc_q),
    .divisor(opnd_nxt), .done(div_done), .quotient(div_quot)
  );

  // Outputs stay quiet during reset and for the first cycle after it.
  assign en = rst & init_q;

  always_comb begin
    in_rdy = 1'b0;
    case (state_q)
      S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_OPND, S_DRAIN: in_rdy = 1'b1;
      // Never take a byte beyond the end of the echoed payload.
      S_ECHO:  in_rdy = (len_q != '0) && (!out_valid_q || bus.out_ready_i);
      default: in_rdy = 1'b0;
    endcase
    in_rdy = in_rdy & en;
  end

  assign take      = in_rdy & bus.in_valid_i;
  assign len_hdr   = {bus.in_data_i, len_q[7:0]};
  assign opnd_nxt  = opnd_q | (DATA_W'(bus.in_data_i) << (8 * bcnt_q));
  assign last_byte = (len_q == 16'd1);
  assign opnd_done = last_byte || (bcnt_q == BC_W'(BYTES_W - 1));
  assign acc_sh    = acc_q >> 8;

  always_comb begin
    state_d = state_q; op_d = op_q; len_d = len_q; opnd_d = opnd_q;
    bcnt_d = bcnt_q; acc_d = acc_q; first_d = first_q; last_d = last_q;
    out_data_d = out_data_q; out_valid_d = out_valid_q; ecnt_d = ecnt_q;
    div_start = 1'b0; res = acc_q; emit = 1'b0;
    case (state_q)
      S_HDR0: if (take) begin op_d = bus.in_data_i; state_d = S_HDR1; end
      S_HDR1: if (take) state_d = S_HDR2;
      S_HDR2: if (take) begin len_d = {8'h00, bus.in_data_i}; state_d = S_HDR3; end
      S_HDR3: if (take) begin
        len_d = len_hdr; bcnt_d = '0; opnd_d = '0; first_d = 1'b1;
        res = (op_q == OP_MUL) ? DATA_W'(1) : '0;
        acc_d = res;
        if (len_hdr == '0) begin
          emit    = is_arith(op_q);
          state_d = S_HDR0;
        end else if (op_q == OP_ECHO) state_d = S_ECHO;
        else if (is_arith(op_q))      state_d = S_OPND;
        else                          state_d = S_DRAIN;
      end
      S_OPND: if (take) begin
        len_d = len_q - 16'd1; opnd_d = opnd_nxt; bcnt_d = bcnt_q + 1'b1;
        if (opnd_done) begin
          opnd_d = '0; bcnt_d = '0; first_d = 1'b0;
          if (op_q == OP_DIV && !first_q) begin
            div_start = 1'b1; last_d = last_byte; state_d = S_DIVW;
          end else begin
            case (op_q)
              OP_ADD:  res = acc_q + opnd_nxt;
              OP_MUL:  res = acc_q * opnd_nxt;
              default: res = opnd_nxt;
            endcase
            acc_d = res;
            emit  = last_byte;
          end
        end
      end
      S_DIVW: if (div_done) begin
        res = div_quot; acc_d = res;
        if (last_q) emit = 1'b1;
        else        state_d = S_OPND;
      end
      S_EMIT: if (bus.out_ready_i) begin
        if (ecnt_q == '0) begin
          out_valid_d = 1'b0; state_d = S_HDR0;
        end else begin
          acc_d = acc_sh; out_data_d = acc_sh[7:0]; ecnt_d = ecnt_q - 1'b1;
        end
      end
      S_ECHO: begin
        if (take) begin
          out_data_d = bus.in_data_i; out_valid_d = 1'b1; len_d = len_q - 16'd1;
        end else if (bus.out_ready_i) out_valid_d = 1'b0;
        if (len_q == '0 && (!out_valid_q || bus.out_ready_i)) begin
          out_valid_d = 1'b0; state_d = S_HDR0;
        end
      end
      S_DRAIN: if (take) begin
        len_d = len_q - 16'd1;
        if (last_byte) state_d = S_HDR0;
      end
      default: state_d = S_HDR0;
    endcase
    if (emit) begin
      state_d = S_EMIT; acc_d = res; out_valid_d = 1'b1;
      out_data_d = res[7:0]; ecnt_d = BC_W'(BYTES_W - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_HDR0; op_q <= '0; len_q <= '0; opnd_q <= '0; bcnt_q <= '0;
      acc_q <= '0; first_q <= 1'b0; last_q <= 1'b0; out_data_q <= '0;
      out_valid_q <= 1'b0; ecnt_q <= '0; init_q <= 1'b0;
    end else begin
      state_q <= state_d; op_q <= op_d; len_q <= len_d; opnd_q <= opnd_d;
      bcnt_q <= bcnt_d; acc_q <= acc_d; first_q <= first_d; last_q <= last_d;
      out_data_q <= out_data_d; out_valid_q <= out_valid_d; ecnt_q <= ecnt_d;
      init_q <= 1'b1;
    end
  end

  assign bus.in_ready_o  = in_rdy;
  assign bus.out_valid_o = en & out_valid_q;
  assign bus.out_data_o  = en ? out_data_q : 8'h00;
  assign bus.busy_o      = en & (state_q != S_HDR0);
endmodule

// File: tb/tb_stream_alu.sv
// Randomised and directed checks of stream_alu (DATA_W=32) against a packet-level model.
module tb_stream_alu;
  import config_pkg::*;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam longint unsigned MASK = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stream_alu_if bus ();
  stream_alu #(.DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, errors = 0;
  int rdy_mode = 0;
  logic tog = 1'b0;
  bit hung = 1'b0;
  byte unsigned got[$], exp_q[$], pay[$];
  int lowruns[$];
  int lowcnt = 0;

  // Sink side: drive out_ready, collect handshaken bytes, measure in_ready-low runs.
  always @(negedge clk) begin
    case (rdy_mode)
      0: bus.out_ready_i = 1'b1;
      1: begin bus.out_ready_i = tog; tog = ~tog; end
      2: bus.out_ready_i = 1'($urandom_range(0, 1));
      default: bus.out_ready_i = 1'b0;
    endcase
    #2;
    if (rst && bus.out_valid_o && bus.out_ready_i) got.push_back(bus.out_data_o);
    if (bus.busy_o && !bus.in_ready_o) lowcnt++;
    else if (lowcnt > 0) begin lowruns.push_back(lowcnt); lowcnt = 0; end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (hung) return;
    @(negedge clk);
    bus.in_valid_i = 1'b1; bus.in_data_i = b;
    #1;
    while (!bus.in_ready_o) begin
      if (n >= 5000) begin
        errors++; hung = 1'b1;
        $display("FAIL in_ready timeout: got 0 for 5000 cycles, required 1");
        return;
      end
      @(negedge clk); #1; n++;
    end
  endtask

  task automatic send_pkt(input logic [7:0] op, input int len);
    send_byte(op);
    send_byte(8'($urandom));
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    for (int i = 0; i < len; i++) send_byte(pay[i]);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    if (hung) return;
    @(negedge clk); #3;
    while (bus.busy_o || bus.out_valid_o) begin
      if (n >= bound) begin
        errors++; hung = 1'b1;
        $display("FAIL idle timeout: busy=%0b out_valid=%0b, required 0 0", bus.busy_o, bus.out_valid_o);
        return;
      end
      @(negedge clk); #3; n++;
    end
    repeat (2) @(negedge clk);
  endtask

  // Reference: packet semantics in plain integer arithmetic.
  task automatic model_pkt(input logic [7:0] op, input int len);
    longint unsigned acc, val;
    int nops;
    exp_q.delete();
    if (op == OP_ECHO) begin
      for (int i = 0; i < len; i++) exp_q.push_back(pay[i]);
    end else if (op == OP_ADD || op == OP_MUL || op == OP_DIV) begin
      acc  = (op == OP_MUL) ? 1 : 0;
      nops = (len + BW - 1) / BW;
      for (int i = 0; i < nops; i++) begin
        val = 0;
        for (int k = 0; k < BW; k++)
          if (i * BW + k < len) val += longint'(pay[i * BW + k]) << (8 * k);
        if (op == OP_ADD)      acc = (acc + val) & MASK;
        else if (op == OP_MUL) acc = (acc * val) & MASK;
        else if (i == 0)       acc = val;
        else                   acc = (val == 0) ? MASK : acc / val;
      end
      for (int k = 0; k < BW; k++) exp_q.push_back(8'((acc >> (8 * k)) & 64'hFF));
    end
  endtask

  function automatic logic [31:0] got_word();
    if (got.size() < 4) return 32'hxxxx_xxxx;
    return {got[3], got[2], got[1], got[0]};
  endfunction

  task automatic set_pay(input int len, input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    logic [95:0] all;
    all = {w2, w1, w0};
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(all[8 * i +: 8]);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #3; checks++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.out_data_o, bus.busy_o} !== 11'h0)
      begin errors++; $display("FAIL reset_hold: outputs=%h required 0", {bus.in_ready_o, bus.out_valid_o, bus.out_data_o, bus.busy_o}); end
    rst = 1'b1;
    #1; checks++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.out_data_o, bus.busy_o} !== 11'h0)
      begin errors++; $display("FAIL reset_after: outputs=%h required 0", {bus.in_ready_o, bus.out_valid_o, bus.out_data_o, bus.busy_o}); end
    @(negedge clk); #3; checks++;
    if ({bus.in_ready_o, bus.busy_o} !== 2'b10)
      begin errors++; $display("FAIL reset_idle: ready,busy=%b required 10", {bus.in_ready_o, bus.busy_o}); end
  endtask

  task automatic test_add();
    got.delete(); set_pay(8, 32'hFFFF_FFFF, 32'h2, 0);
    send_pkt(OP_ADD, 8); wait_idle(200);
    checks++; if (got.size() != 4 || got_word() !== 32'h1)
      begin errors++; $display("FAIL add_wrap: got %0d bytes word %h, required 4 bytes 00000001", got.size(), got_word()); end
  endtask

  task automatic test_mul();
    got.delete(); set_pay(6, 32'h3, 32'h5, 0);
    send_pkt(OP_MUL, 6); wait_idle(200);
    checks++; if (got.size() != 4 || got_word() !== 32'hF)
      begin errors++; $display("FAIL mul_partial: got %0d bytes word %h, required 4 bytes 0000000f", got.size(), got_word()); end
    got.delete(); pay.delete();
    send_pkt(OP_MUL, 0); wait_idle(200);
    checks++; if (got.size() != 4 || got_word() !== 32'h1)
      begin errors++; $display("FAIL mul_len0: got %0d bytes word %h, required 4 bytes 00000001", got.size(), got_word()); end
  endtask

  task automatic test_div();
    got.delete(); set_pay(8, 100, 7, 0);
    send_pkt(OP_DIV, 8); wait_idle(200);
    checks++; if (got.size() != 4 || got_word() !== 32'd14)
      begin errors++; $display("FAIL div_basic: got %0d bytes word %h, required 4 bytes 0000000e", got.size(), got_word()); end
    got.delete(); set_pay(12, 100, 7, 0);
    lowruns.delete(); lowcnt = 0;
    send_pkt(OP_DIV, 12); wait_idle(300);
    checks++; if (got.size() != 4 || got_word() !== 32'hFFFF_FFFF)
      begin errors++; $display("FAIL div_zero: got %0d bytes word %h, required 4 bytes ffffffff", got.size(), got_word()); end
    // first divisor: 32 stall cycles; last divisor: 32 stall cycles followed by 4 emit cycles
    checks++; if (lowruns.size() != 2 || lowruns[0] != 32 || lowruns[1] != 36)
      begin errors++; $display("FAIL div_stall: runs=%0d first=%0d second=%0d, required 2 runs 32 36",
        lowruns.size(), (lowruns.size() > 0) ? lowruns[0] : -1, (lowruns.size() > 1) ? lowruns[1] : -1); end
  endtask

  task automatic test_echo();
    got.delete(); pay = '{8'h41, 8'h42, 8'h43};
    rdy_mode = 1;
    send_pkt(OP_ECHO, 3); wait_idle(200);
    rdy_mode = 0;
    checks++; if (got.size() != 3 || got[0] != 8'h41 || got[1] != 8'h42 || got[2] != 8'h43)
      begin errors++; $display("FAIL echo_toggle: got %0d bytes, required 41 42 43", got.size()); end
    checks++; if (bus.busy_o !== 1'b0)
      begin errors++; $display("FAIL echo_busy: busy=%b required 0", bus.busy_o); end
  endtask

  task automatic test_unknown();
    got.delete(); pay = '{8'h12, 8'h34};
    send_pkt(8'h55, 2);
    set_pay(4, 5, 0, 0);
    send_pkt(OP_ADD, 4); wait_idle(200);
    checks++; if (got.size() != 4 || got_word() !== 32'd5)
      begin errors++; $display("FAIL unknown_drain: got %0d bytes word %h, required 4 bytes 00000005", got.size(), got_word()); end
  endtask

  task automatic test_reset_mid();
    int n;
    // reset while dividing
    got.delete(); set_pay(8, 100, 7, 0);
    send_pkt(OP_DIV, 8);
    rst = 1'b0;
    @(negedge clk); #3; checks++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.out_data_o, bus.busy_o} !== 11'h0)
      begin errors++; $display("FAIL rst_divw: outputs=%h required 0", {bus.in_ready_o, bus.out_valid_o, bus.out_data_o, bus.busy_o}); end
    rst = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (got.size() != 0 || bus.busy_o !== 1'b0)
      begin errors++; $display("FAIL rst_divw_out: got %0d bytes busy=%b, required 0 bytes busy 0", got.size(), bus.busy_o); end
    set_pay(4, 32'h0102_0304, 0, 0);
    send_pkt(OP_ADD, 4); wait_idle(200);
    checks++; if (got.size() != 4 || got_word() !== 32'h0102_0304)
      begin errors++; $display("FAIL rst_divw_next: got %0d bytes word %h, required 4 bytes 01020304", got.size(), got_word()); end
    // reset while a result is held by a stalled transmitter
    got.delete(); rdy_mode = 3; set_pay(4, 32'h1122_3344, 0, 0);
    send_pkt(OP_ADD, 4);
    n = 0;
    while (!bus.out_valid_o && n < 50) begin @(negedge clk); #3; n++; end
    repeat (3) @(negedge clk);
    #3; checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 8'h44)
      begin errors++; $display("FAIL emit_hold: valid=%b data=%h, required 1 44", bus.out_valid_o, bus.out_data_o); end
    rst = 1'b0;
    @(negedge clk); #3; checks++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.out_data_o, bus.busy_o} !== 11'h0)
      begin errors++; $display("FAIL rst_emit: outputs=%h required 0", {bus.in_ready_o, bus.out_valid_o, bus.out_data_o, bus.busy_o}); end
    rst = 1'b1; rdy_mode = 0;
    repeat (10) @(negedge clk);
    checks++; if (got.size() != 0)
      begin errors++; $display("FAIL rst_emit_out: got %0d bytes, required 0", got.size()); end
    set_pay(8, 32'h7, 32'h9, 0);
    send_pkt(OP_ADD, 8); wait_idle(200);
    checks++; if (got.size() != 4 || got_word() !== 32'd16)
      begin errors++; $display("FAIL rst_emit_next: got %0d bytes word %h, required 4 bytes 00000010", got.size(), got_word()); end
  endtask

  task automatic test_random();
    logic [7:0] ops [5] = '{OP_ADD, OP_MUL, OP_DIV, OP_ECHO, 8'h00};
    logic [7:0] op;
    int len, bad;
    for (int p = 0; p < 12; p++) begin
      op = ops[$urandom_range(0, 4)];
      if (op == 8'h00) op = 8'($urandom_range(0, 255));
      len = $urandom_range(0, 13);
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
      if (op == OP_DIV && len > 4 && ($urandom_range(0, 1) == 1)) pay[4] = 8'($urandom_range(1, 9));
      model_pkt(op, len);
      rdy_mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      got.delete();
      send_pkt(op, len); wait_idle(500);
      rdy_mode = 0;
      bad = 0;
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) if (got[i] != exp_q[i]) bad++;
      checks++; if (got.size() != exp_q.size() || bad != 0)
        begin errors++; $display("FAIL random_pkt op=%h len=%0d: got %0d bytes (%0d differ), required %0d bytes",
          op, len, got.size(), bad, exp_q.size()); end
    end
  endtask

  task automatic test_back_to_back();
    got.delete(); pay.delete();
    for (int i = 0; i < 65535; i++) pay.push_back(8'($urandom));
    model_pkt(OP_ADD, 65535);
    send_pkt(OP_ADD, 65535); wait_idle(500);
    checks++; if (got.size() != 4 || got_word() !== {exp_q[3], exp_q[2], exp_q[1], exp_q[0]})
      begin errors++; $display("FAIL add_maxlen: got %0d bytes word %h, required 4 bytes %h",
        got.size(), got_word(), {exp_q[3], exp_q[2], exp_q[1], exp_q[0]}); end
  endtask

  initial begin
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = 8'h00;
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_echo();
    test_unknown();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
